mux_arb_nto1: RTL and testbench
===============================

// Module: mux_arb_nto1
// PURPOSE
//   Parametrised N-to-1 registered multiplexer with arbitration: selects one of CHANNELS
//   valid/ready input streams of WIDTH bits, registers the winner, and presents it with its index.
//   Generalises the fixed 8:1 select mux: the select comes from an internal round-robin or
//   fixed-priority arbiter, not from external select pins. Used where several requesters
//   (IF fetch, MEM load/store, debug) share one memory or bus port.
// PARAMETERS
//   WIDTH     32  data bits per channel
//   CHANNELS  8   number of input channels, 2..16, need not be a power of two
//   MODE      0   0 = round-robin, 1 = fixed priority (lowest index wins)
//   SEL_W     localparam = clog2(CHANNELS), minimum 1
// PORTS
//   clk       in   1                clock, all state on rising edge
//   rst       in   1                synchronous, active-high reset
//   in_valid  in   CHANNELS         bit k: channel k offers a word
//   in_data   in   CHANNELS*WIDTH   channel k word at [k*WIDTH +: WIDTH]
//   in_ready  out  CHANNELS         one-hot or zero: channel k word accepted this cycle
//   out_valid out  1                out_data/out_sel hold a word
//   out_data  out  WIDTH            registered selected word
//   out_sel   out  SEL_W            index of the channel that supplied out_data
//   out_ready in   1                consumer takes the word when out_valid && out_ready
// BEHAVIOUR
//   - Reset (rst=1 at edge): out_valid=0, out_data=0, out_sel=0, rr pointer=0; while rst=1
//     in_ready=0 (combinationally gated). A held, unconsumed word is dropped.
//   - load = !out_valid || out_ready. A transfer from channel g happens when load && in_valid[g]
//     && g is the grant; then in_ready[g]=1, all other in_ready bits 0.
//   - in_ready is combinational from in_valid, pointer, out_valid and out_ready; no comb path
//     from in_data to out_data.
//   - Latency: a word accepted at edge t appears on out_data at t+1 with out_valid=1.
//   - Throughput: one word per cycle when out_ready is held high (simultaneous consume + load).
//   - Output stability: while out_valid && !out_ready, out_data and out_sel hold and in_ready=0.
//   - No valid input at a load cycle: out_valid falls to 0 after consume; out_data keeps its
//     old value (don't-care to consumer), pointer unchanged.
//   - Grant, MODE=0: first k with in_valid[k] searching ptr, ptr+1, .. CHANNELS-1, 0, .. ptr-1.
//     On transfer from g, ptr <= (g == CHANNELS-1) ? 0 : g+1. Pointer moves only on transfer.
//   - Grant, MODE=1: lowest k with in_valid[k]; pointer register unused, held at 0.
//   - Fairness (MODE=0): a channel held valid waits at most CHANNELS-1 transfers.
//   - Inputs must hold in_valid/in_data until in_ready; block does not check protocol.
//   - Non-power-of-two CHANNELS: ptr never reaches >= CHANNELS; wrap is explicit compare.
// STRUCTURE
//   - Shared defs include: MODE_RR=0, MODE_FIXED=1 encodings and the clog2 function macro.
//   - Sub-module rr_grant: combinational, in: req[CHANNELS], ptr[SEL_W], mode; out:
//     grant_oh[CHANNELS], grant_idx[SEL_W], any. Implement by double-width request vector
//     masked from ptr, priority-encode, fold back modulo CHANNELS.
//   - Top: rr_grant instance, pointer register, output register bank, data mux driven by
//     grant_idx (generate loop, AND-OR over one-hot).
// TESTING
//   1 Reset: drive all in_valid=1, rst=1 for 2 cycles -> in_ready=0, out_valid=0, out_sel=0;
//     first cycle after release grants ch0, out_data=ch0 word one cycle later.
//   2 RR rotation: CHANNELS=8, all 8 valid, out_ready=1, ch k data=32'h100+k -> out_sel 0..7
//     then 0 again, one per cycle, out_data matches, no bubbles.
//   3 Backpressure: out_ready=0 for 4 cycles with word from ch2 held -> out_data/out_sel stable,
//     in_ready=0; out_ready=1 -> ch2 consumed and next grant (ch3 if valid) loads same cycle.
//   4 Wrap + sparse: CHANNELS=5, valid only ch4 and ch1, ptr=4 -> grants 4,1,4,1; ptr wraps to 0.
//   5 Fixed priority: MODE=1, ch1,ch3,ch6 valid, out_ready=1 -> ch1 granted every cycle,
//     ch3/ch6 starve while ch1 valid; drop ch1 -> ch3 next.
//   6 Reset mid-operation: out_valid=1 from ch5, ptr=6, assert rst one cycle -> out_valid=0,
//     ptr=0; held word never seen by consumer.

Source files
------------

// File: rtl/mux_arb_nto1_pkg.sv
// rtl/mux_arb_nto1_pkg.sv - shared arbitration mode encodings and select-width helper
package mux_arb_nto1_pkg;

   localparam int MODE_RR    = 0;
   localparam int MODE_FIXED = 1;

   // Select width for n channels, never below one bit.
   function automatic int sel_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mux_arb_nto1_rr_grant.sv
// rtl/mux_arb_nto1_rr_grant.sv - combinational round-robin / fixed-priority grant
module mux_arb_nto1_rr_grant
   import mux_arb_nto1_pkg::*;
#(
   parameter int CHANNELS = 8,
   parameter int SEL_W    = sel_width(CHANNELS)
) (
   input  logic [CHANNELS-1:0] req,
   input  logic [SEL_W-1:0]    ptr,
   input  logic                mode,
   output logic [CHANNELS-1:0] grant_oh,
   output logic [SEL_W-1:0]    grant_idx,
   output logic                any
);

   logic [2*CHANNELS-1:0] dbl_req;
   logic [SEL_W-1:0]      start;
   int                    pos;
   int                    idx;

   // Upper copy of req covers the wrapped-around part of the search, so the
   // lowest set bit of the masked double vector is the rotating winner.
   always_comb begin
      start   = (mode == 1'(MODE_FIXED)) ? '0 : ptr;
      dbl_req = '0;
      for (int i = 0; i < 2*CHANNELS; i++) begin
         dbl_req[i] = req[i % CHANNELS] && (i >= int'(start));
      end
      any = 1'b0;
      pos = 0;
      for (int i = 2*CHANNELS-1; i >= 0; i--) begin
         if (dbl_req[i]) begin
            any = 1'b1;
            pos = i;
         end
      end
      idx       = (pos >= CHANNELS) ? pos - CHANNELS : pos;
      grant_idx = SEL_W'(idx);
      grant_oh  = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         grant_oh[k] = any && (idx == k);
      end
   end

endmodule

// File: rtl/mux_arb_nto1.sv
// rtl/mux_arb_nto1.sv - N-to-1 registered stream mux with internal arbiter
module mux_arb_nto1
   import mux_arb_nto1_pkg::*;
#(
   parameter  int WIDTH    = 32,
   parameter  int CHANNELS = 8,
   parameter  int MODE     = MODE_RR,
   localparam int SEL_W    = sel_width(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS-1:0]       in_valid,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   output logic [CHANNELS-1:0]       in_ready,
   output logic                      out_valid,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_sel,
   input  logic                      out_ready
);

   localparam logic MODE_BIT = (MODE == MODE_FIXED);

   logic [CHANNELS-1:0] grant_oh;
   logic [SEL_W-1:0]    grant_idx;
   logic [SEL_W-1:0]    ptr;
   logic                any;
   logic                load;
   logic                xfer;
   logic [WIDTH-1:0]    term [CHANNELS];
   logic [WIDTH-1:0]    sel_data;

   mux_arb_nto1_rr_grant #(
      .CHANNELS (CHANNELS),
      .SEL_W    (SEL_W)
   ) u_grant (
      .req       (in_valid),
      .ptr       (ptr),
      .mode      (MODE_BIT),
      .grant_oh  (grant_oh),
      .grant_idx (grant_idx),
      .any       (any)
   );

   assign load     = !out_valid || out_ready;
   assign in_ready = (load && !rst) ? grant_oh : '0;
   assign xfer     = load && any && !rst;

   for (genvar k = 0; k < CHANNELS; k++) begin : g_term
      assign term[k] = in_data[k*WIDTH +: WIDTH] & {WIDTH{grant_oh[k]}};
   end

   always_comb begin
      sel_data = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         sel_data = sel_data | term[k];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         ptr       <= '0;
      end else if (load) begin
         out_valid <= xfer;
         if (xfer) begin
            out_data <= sel_data;
            out_sel  <= grant_idx;
            // Explicit wrap keeps ptr inside 0..CHANNELS-1 for non-power-of-two sizes.
            if (MODE == MODE_RR) begin
               ptr <= (grant_idx == SEL_W'(CHANNELS-1)) ? '0 : grant_idx + SEL_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_mux_arb_nto1.sv
// tb/tb_mux_arb_nto1.sv - randomized check of three mux_arb_nto1 configurations against a queue-level model
module tb_mux_arb_nto1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Instance 0: 8ch round-robin, 1: 5ch round-robin, 2: 8ch fixed priority.
   int   nch   [3] = '{8, 5, 8};
   int   mmode [3] = '{0, 0, 1};

   logic [15:0] v_all [3];
   logic [31:0] d_all [3][16];
   logic        ordy  [3];

   logic [7:0]   iv0, iv2, ir0, ir2;
   logic [4:0]   iv1, ir1;
   logic [255:0] id0, id2;
   logic [159:0] id1;
   logic         ov0, ov1, ov2;
   logic [31:0]  od0, od1, od2;
   logic [2:0]   os0, os1, os2;

   assign iv0 = v_all[0][7:0];
   assign iv1 = v_all[1][4:0];
   assign iv2 = v_all[2][7:0];
   for (genvar k = 0; k < 8; k++) begin : g_d8
      assign id0[k*32 +: 32] = d_all[0][k];
      assign id2[k*32 +: 32] = d_all[2][k];
   end
   for (genvar k = 0; k < 5; k++) begin : g_d5
      assign id1[k*32 +: 32] = d_all[1][k];
   end

   mux_arb_nto1 #(.WIDTH(32), .CHANNELS(8), .MODE(0)) u_rr8 (
      .clk(clk), .rst(rst), .in_valid(iv0), .in_data(id0), .in_ready(ir0),
      .out_valid(ov0), .out_data(od0), .out_sel(os0), .out_ready(ordy[0]));
   mux_arb_nto1 #(.WIDTH(32), .CHANNELS(5), .MODE(0)) u_rr5 (
      .clk(clk), .rst(rst), .in_valid(iv1), .in_data(id1), .in_ready(ir1),
      .out_valid(ov1), .out_data(od1), .out_sel(os1), .out_ready(ordy[1]));
   mux_arb_nto1 #(.WIDTH(32), .CHANNELS(8), .MODE(1)) u_fix8 (
      .clk(clk), .rst(rst), .in_valid(iv2), .in_data(id2), .in_ready(ir2),
      .out_valid(ov2), .out_data(od2), .out_sel(os2), .out_ready(ordy[2]));

   logic [15:0] ir_all [3];
   logic        ov_all [3];
   logic [31:0] od_all [3];
   logic [3:0]  os_all [3];
   assign ir_all[0] = 16'(ir0);
   assign ir_all[1] = 16'(ir1);
   assign ir_all[2] = 16'(ir2);
   assign ov_all[0] = ov0;
   assign ov_all[1] = ov1;
   assign ov_all[2] = ov2;
   assign od_all[0] = od0;
   assign od_all[1] = od1;
   assign od_all[2] = od2;
   assign os_all[0] = 4'(os0);
   assign os_all[1] = 4'(os1);
   assign os_all[2] = 4'(os2);

   // Reference state: what the output register should hold, and the rotation start.
   logic        mv [3];
   logic [31:0] md [3];
   int          ms [3];
   int          mp [3];
   int          pend_g [3];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Rotating search from ptr for round-robin, lowest index for fixed priority; -1 if none.
   function automatic int ref_grant(input logic [15:0] v, input int n, input int mode, input int ptr);
      if (mode == 1) begin
         for (int k = 0; k < n; k++) if (v[k]) return k;
      end else begin
         for (int j = 0; j < n; j++) if (v[(ptr + j) % n]) return (ptr + j) % n;
      end
      return -1;
   endfunction

   task automatic cycle(input bit do_rst, input int pv, input int pr, input bit fixed_data);
      int g;
      bit load;
      logic [15:0] exp_ir;
      @(negedge clk);
      rst = do_rst;
      for (int id = 0; id < 3; id++) begin
         if (pend_g[id] >= 0) v_all[id][pend_g[id]] = 1'b0;
         pend_g[id] = -1;
         check_eq($sformatf("out_valid[%0d]", id), 32'(ov_all[id]), 32'(mv[id]));
         check_eq($sformatf("out_data[%0d]", id), od_all[id], md[id]);
         check_eq($sformatf("out_sel[%0d]", id), 32'(os_all[id]), 32'(ms[id]));
         for (int k = 0; k < nch[id]; k++) begin
            if (!v_all[id][k] && $urandom_range(99) < pv) begin
               v_all[id][k] = 1'b1;
               d_all[id][k] = fixed_data ? 32'h100 + 32'(k) : $urandom;
            end
         end
         ordy[id] = ($urandom_range(99) < pr);
      end
      #1;
      for (int id = 0; id < 3; id++) begin
         load = !mv[id] || ordy[id];
         g = (load && !do_rst) ? ref_grant(v_all[id], nch[id], mmode[id], mp[id]) : -1;
         exp_ir = (g >= 0) ? (16'd1 << g) : 16'd0;
         check_eq($sformatf("in_ready[%0d]", id), 32'(ir_all[id]), 32'(exp_ir));
         if (do_rst) begin
            mv[id] = 1'b0;
            md[id] = '0;
            ms[id] = 0;
            mp[id] = 0;
         end else if (load) begin
            if (g >= 0) begin
               mv[id] = 1'b1;
               md[id] = d_all[id][g];
               ms[id] = g;
               mp[id] = (mmode[id] == 0) ? (g + 1) % nch[id] : 0;
               pend_g[id] = g;
            end else begin
               mv[id] = 1'b0;
            end
         end
      end
   endtask

   initial begin
      int pv, pr;
      for (int id = 0; id < 3; id++) begin
         v_all[id]  = '0;
         ordy[id]   = 1'b0;
         mv[id]     = 1'b0;
         md[id]     = '0;
         ms[id]     = 0;
         mp[id]     = 0;
         pend_g[id] = -1;
         for (int k = 0; k < 16; k++) d_all[id][k] = '0;
      end
      // Reset with every channel offering, then full-throughput rotation.
      repeat (2) cycle(1'b1, 100, 100, 1'b1);
      repeat (24) cycle(1'b0, 100, 100, 1'b1);
      // Mixed density, backpressure and occasional reset pulses.
      pv = 50;
      pr = 50;
      for (int i = 0; i < 3000; i++) begin
         if (i % 100 == 0) begin
            pv = $urandom_range(90, 5);
            pr = $urandom_range(100, 0);
         end
         cycle(($urandom_range(199) == 0), pv, pr, 1'b0);
      end
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
